// File: rtl/conv2d_window_feeder_if.sv
// Pixel-in / 3x3-window-out stream bundle for conv2d_window_feeder.
// master = upstream source plus downstream sink, slave = the feeder itself.
interface conv2d_window_feeder_if #(
  parameter int DATA_W = 32
);
  logic                  valid_in;
  logic                  ready_in;
  logic [DATA_W-1:0]     pixel_in;
  logic                  sof_in;
  logic                  valid_out;
  logic                  ready_out;
  logic [9*DATA_W-1:0]   win_out;
  logic                  last_out;
  logic                  err_out;

  modport master (
    output valid_in, pixel_in, sof_in, ready_out,
    input  ready_in, valid_out, win_out, last_out, err_out
  );

  modport slave (
    input  valid_in, pixel_in, sof_in, ready_out,
    output ready_in, valid_out, win_out, last_out, err_out
  );
endinterface

// File: rtl/conv2d_window_feeder.sv
// Raster pixels -> 3x3 stride-1 windows; 1-cycle latency, single output register, ready_in = !valid_out || ready_out.
// Define FEEDER_SOF_CHECK_EN to resync on sof_in and pulse err_out on misplaced frame starts.
module conv2d_window_feeder #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  conv2d_window_feeder_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       col, eff_col;
  logic [RW-1:0]       row, eff_row;
  logic                acc;
  logic                sof_restart;
  logic                sof_err;
  logic                win_ld;
  logic                last_ld;

  logic [DATA_W-1:0]   lb0 [IMG_W];
  logic [DATA_W-1:0]   lb1 [IMG_W];
  logic [DATA_W-1:0]   p1 [3];
  logic [DATA_W-1:0]   p2 [3];
  logic [DATA_W-1:0]   nc [3];
  logic [9*DATA_W-1:0] win_nxt;

  logic                vld_q;
  logic                last_q;
  logic                err_q;
  logic [9*DATA_W-1:0] win_q;

  assign bus.ready_in  = !vld_q || bus.ready_out;
  assign acc           = bus.valid_in && bus.ready_in;
  assign bus.valid_out = vld_q;
  assign bus.win_out   = win_q;
  assign bus.last_out  = last_q;
  assign bus.err_out   = err_q;

`ifdef FEEDER_SOF_CHECK_EN
  assign sof_restart = acc && bus.sof_in && ((row != '0) || (col != '0));
  assign sof_err     = acc && (bus.sof_in != ((row == '0) && (col == '0)));
`else
  logic unused_sof;
  assign unused_sof  = bus.sof_in;
  assign sof_restart = 1'b0;
  assign sof_err     = 1'b0;
`endif

  // A resync pixel is processed as if it sat at (0,0).
  assign eff_col = sof_restart ? '0 : col;
  assign eff_row = sof_restart ? '0 : row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (acc) begin
      if (sof_restart) begin
        state_nxt = FILL;
      end else begin
        case (state)
          FILL: if (eff_row == RW'(1) && eff_col == COL_LAST) state_nxt = RUN;
          RUN:  if (eff_row == ROW_LAST && eff_col == COL_LAST) state_nxt = FILL;
          default: state_nxt = FILL;
        endcase
      end
    end
  end

  always_comb begin
    win_ld  = acc && (state == RUN) && !sof_restart && (eff_col >= CW'(2));
    last_ld = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (eff_col == COL_LAST) begin
        col <= '0;
        row <= (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
      end else begin
        col <= eff_col + CW'(1);
        row <= eff_row;
      end
    end
  end

  // New column: two rows up, one row up, current pixel (r=0 oldest).
  always_comb begin
    nc[0] = lb0[eff_col];
    nc[1] = lb1[eff_col];
    nc[2] = bus.pixel_in;
    win_nxt = '0;
    for (int r = 0; r < 3; r++) begin
      win_nxt[DATA_W*(3*r)   +: DATA_W] = p2[r];
      win_nxt[DATA_W*(3*r+1) +: DATA_W] = p1[r];
      win_nxt[DATA_W*(3*r+2) +: DATA_W] = nc[r];
    end
  end

  // Storage is deliberately unreset; window gating keeps stale words invisible.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb0[eff_col] <= lb1[eff_col];
      lb1[eff_col] <= bus.pixel_in;
      for (int r = 0; r < 3; r++) begin
        p1[r] <= nc[r];
        p2[r] <= p1[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
      win_q  <= '0;
    end else begin
      err_q <= sof_err;
      if (win_ld) begin
        vld_q  <= 1'b1;
        win_q  <= win_nxt;
        last_q <= last_ld;
      end else if (bus.ready_out) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end
    end
  end
endmodule
